imm_decode_stage: RTL and testbench

Registered RV32I/RV64I immediate decoder for the pipelined core. It takes a full 32-bit instruction word and classifies its format from the opcode. It produces the sign-extended XLEN immediate, with correct bit scrambling for I/S/B/U/J and shift-amount forms. Sits between fetch and the decode/execute register, with valid/ready handshakes on both sides and a 2-entry skid buffer so `in_ready` is purely registered.

---
 rtl/imm_decode_stage.sv | 167 ++++++++++++++++
 tb/tb_imm_decode_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered RV32I/RV64I immediate decoder.
// Decodes the instruction format from the opcode and builds the sign-extended
// XLEN immediate. A main register drives the outputs and a one-entry skid
// register absorbs a word during a stall, so in_ready comes straight from a flop.
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_SH  = 3'd6;
  localparam logic [2:0] FMT_ILL = 3'd7;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [6:0]             w_opcode;
  logic [2:0]             w_funct3;
  logic signed [31:0]     w_imm32_p0;
  logic signed [XLEN-1:0] w_imm_p0;
  logic [2:0]             w_fmt_p0;
  logic                   w_ill_p0;
  logic                   w_accept;
  logic                   w_pop;

  logic                   r_main_vld_p1;
  logic signed [XLEN-1:0] r_main_imm_p1;
  logic [2:0]             r_main_fmt_p1;
  logic                   r_main_ill_p1;
  logic                   r_skid_vld_p1;
  logic signed [XLEN-1:0] r_skid_imm_p1;
  logic [2:0]             r_skid_fmt_p1;
  logic                   r_skid_ill_p1;
  logic [CNT_W-1:0]       r_err_cnt;

  assign w_opcode = in_inst[6:0];
  assign w_funct3 = in_inst[14:12];

  // ---- Stage p0: combinational format classification and immediate assembly
  // Every signed format is built as a 32-bit value whose bit 31 is inst[31];
  // shift amounts are built with a zero top bit so one sign extension serves all.
  always_comb begin
    w_imm32_p0 = '0;
    w_fmt_p0   = FMT_ILL;
    w_ill_p0   = 1'b0;
    case (w_opcode)
      7'b0000011, 7'b1100111, 7'b1110011: begin
        w_fmt_p0   = FMT_I;
        w_imm32_p0 = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      7'b0010011: begin
        if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
          w_fmt_p0 = FMT_SH;
          if (XLEN == 64) w_imm32_p0 = {26'b0, in_inst[25:20]};
          else            w_imm32_p0 = {27'b0, in_inst[24:20]};
        end else begin
          w_fmt_p0   = FMT_I;
          w_imm32_p0 = {{20{in_inst[31]}}, in_inst[31:20]};
        end
      end
      7'b0100011: begin
        w_fmt_p0   = FMT_S;
        w_imm32_p0 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      7'b1100011: begin
        w_fmt_p0   = FMT_B;
        w_imm32_p0 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                      in_inst[30:25], in_inst[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        w_fmt_p0   = FMT_U;
        w_imm32_p0 = {in_inst[31:12], 12'b0};
      end
      7'b1101111: begin
        w_fmt_p0   = FMT_J;
        w_imm32_p0 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                      in_inst[20], in_inst[30:21], 1'b0};
      end
      7'b0110011: begin
        w_fmt_p0 = FMT_R;
      end
      default: begin
        w_fmt_p0 = FMT_ILL;
        w_ill_p0 = 1'b1;
      end
    endcase
  end

  assign w_imm_p0 = XLEN'(w_imm32_p0);

  assign in_ready = !r_skid_vld_p1;
  assign w_accept = in_valid && !r_skid_vld_p1;
  assign w_pop    = r_main_vld_p1 && out_ready;

  // ---- Stage p1: main/skid buffer; skid drains into main first to keep FIFO order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_vld_p1 <= 1'b0;
      r_main_imm_p1 <= '0;
      r_main_fmt_p1 <= '0;
      r_main_ill_p1 <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
      r_skid_imm_p1 <= '0;
      r_skid_fmt_p1 <= '0;
      r_skid_ill_p1 <= 1'b0;
    end else if (flush) begin
      r_main_vld_p1 <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
    end else if (!r_main_vld_p1 || w_pop) begin
      if (r_skid_vld_p1) begin
        r_main_vld_p1 <= 1'b1;
        r_main_imm_p1 <= r_skid_imm_p1;
        r_main_fmt_p1 <= r_skid_fmt_p1;
        r_main_ill_p1 <= r_skid_ill_p1;
        r_skid_vld_p1 <= 1'b0;
      end else if (w_accept) begin
        r_main_vld_p1 <= 1'b1;
        r_main_imm_p1 <= w_imm_p0;
        r_main_fmt_p1 <= w_fmt_p0;
        r_main_ill_p1 <= w_ill_p0;
      end else begin
        r_main_vld_p1 <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_vld_p1 <= 1'b1;
      r_skid_imm_p1 <= w_imm_p0;
      r_skid_fmt_p1 <= w_fmt_p0;
      r_skid_ill_p1 <= w_ill_p0;
    end
  end

  // Count accepted illegal words; flush drops the word so it is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (!flush && w_accept && w_ill_p0) begin
      r_err_cnt <= sat_inc(r_err_cnt);
    end
  end

  assign out_valid   = r_main_vld_p1;
  assign out_imm     = r_main_imm_p1;
  assign out_fmt     = r_main_fmt_p1;
  assign out_illegal = r_main_ill_p1;
  assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: one XLEN=32/CNT_W=2 instance and one
// XLEN=64 instance sharing clock, reset and flush.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic        out_illegal;
  logic [1:0]  err_cnt;

  logic        in_valid64;
  logic        in_ready64;
  logic [31:0] in_inst64;
  logic        out_valid64;
  logic        out_ready64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;
  logic        out_illegal64;
  logic [7:0]  err_cnt64;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_illegal(out_illegal), .err_cnt(err_cnt)
  );

  imm_decode_stage #(.XLEN(64), .CNT_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_inst(in_inst64),
    .out_valid(out_valid64), .out_ready(out_ready64), .out_imm(out_imm64),
    .out_fmt(out_fmt64), .out_illegal(out_illegal64), .err_cnt(err_cnt64)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; out_ready = 1'b1;
    in_valid64 = 1'b0; in_inst64 = '0; out_ready64 = 1'b1;
    #3;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %0b exp 0", out_valid); end
    tests++; if (out_imm !== 32'h0) begin fails++; $display("FAIL rst_out_imm got %h exp 0", out_imm); end
    tests++; if (out_fmt !== 3'd0) begin fails++; $display("FAIL rst_out_fmt got %0d exp 0", out_fmt); end
    tests++; if (out_illegal !== 1'b0) begin fails++; $display("FAIL rst_out_illegal got %0b exp 0", out_illegal); end
    tests++; if (err_cnt !== 2'd0) begin fails++; $display("FAIL rst_err_cnt got %0d exp 0", err_cnt); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %0b exp 1", in_ready); end
    step();
    step();
    rst_n = 1'b1;
    step();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_rst_in_ready got %0b exp 1", in_ready); end
  endtask

  task automatic test_formats();
    logic [31:0] insts [9];
    logic [31:0] imms  [9];
    logic [2:0]  fmts  [9];
    insts = '{32'hFFF00093, 32'h00501093, 32'hFE20AE23, 32'hFE000CE3, 32'h001000EF,
              32'h800000B7, 32'h00208033, 32'h80002083, 32'h40515093};
    imms  = '{32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000800,
              32'h80000000, 32'h00000000, 32'hFFFFF800, 32'h00000005};
    fmts  = '{3'd1, 3'd6, 3'd2, 3'd3, 3'd5, 3'd4, 3'd0, 3'd1, 3'd6};
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_inst  = insts[i];
      step();
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL fmt_valid[%0d] got %0b exp 1", i, out_valid); end
      tests++; if (out_imm !== imms[i]) begin fails++; $display("FAIL fmt_imm[%0d] got %h exp %h", i, out_imm, imms[i]); end
      tests++; if (out_fmt !== fmts[i]) begin fails++; $display("FAIL fmt_code[%0d] got %0d exp %0d", i, out_fmt, fmts[i]); end
      tests++; if (out_illegal !== 1'b0) begin fails++; $display("FAIL fmt_illegal[%0d] got %0b exp 0", i, out_illegal); end
    end
    in_valid = 1'b0;
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fmt_drain_valid got %0b exp 0", out_valid); end
    tests++; if (err_cnt !== 2'd0) begin fails++; $display("FAIL fmt_err_cnt got %0d exp 0", err_cnt); end
  endtask

  task automatic test_xlen64();
    in_valid64 = 1'b1;
    in_inst64  = 32'h800000B7;
    step();
    tests++; if (out_imm64 !== 64'hFFFFFFFF80000000) begin fails++; $display("FAIL x64_lui_imm got %h exp ffffffff80000000", out_imm64); end
    tests++; if (out_fmt64 !== 3'd4) begin fails++; $display("FAIL x64_lui_fmt got %0d exp 4", out_fmt64); end
    in_inst64 = 32'h03F01093;
    step();
    tests++; if (out_imm64 !== 64'd63) begin fails++; $display("FAIL x64_sh_imm got %h exp 3f", out_imm64); end
    tests++; if (out_fmt64 !== 3'd6) begin fails++; $display("FAIL x64_sh_fmt got %0d exp 6", out_fmt64); end
    in_inst64 = 32'hFFF00093;
    step();
    tests++; if (out_imm64 !== 64'hFFFFFFFFFFFFFFFF) begin fails++; $display("FAIL x64_addi_imm got %h exp ffffffffffffffff", out_imm64); end
    in_valid64 = 1'b0;
    step();
    tests++; if (out_valid64 !== 1'b0) begin fails++; $display("FAIL x64_drain_valid got %0b exp 0", out_valid64); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h00100093;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready0 got %0b exp 1", in_ready); end
    step();
    tests++; if (out_valid !== 1'b1 || out_imm !== 32'd1) begin fails++; $display("FAIL bp_first got v%0b %h exp v1 00000001", out_valid, out_imm); end
    in_inst = 32'h00200093;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready1 got %0b exp 1", in_ready); end
    step();
    tests++; if (out_imm !== 32'd1) begin fails++; $display("FAIL bp_hold1 got %h exp 00000001", out_imm); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full_ready got %0b exp 0", in_ready); end
    in_inst = 32'h00300093;
    step();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full_ready2 got %0b exp 0", in_ready); end
    tests++; if (out_valid !== 1'b1 || out_imm !== 32'd1) begin fails++; $display("FAIL bp_hold2 got v%0b %h exp v1 00000001", out_valid, out_imm); end
    out_ready = 1'b1;
    step();
    tests++; if (out_valid !== 1'b1 || out_imm !== 32'd2) begin fails++; $display("FAIL bp_second got v%0b %h exp v1 00000002", out_valid, out_imm); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_back got %0b exp 1", in_ready); end
    step();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || out_imm !== 32'd3) begin fails++; $display("FAIL bp_third got v%0b %h exp v1 00000003", out_valid, out_imm); end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got %0b exp 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h00400093;
    step();
    in_inst = 32'h00500093;
    step();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fl_full_ready got %0b exp 0", in_ready); end
    flush   = 1'b1;
    in_inst = 32'h00000000;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fl_valid got %0b exp 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL fl_ready got %0b exp 1", in_ready); end
    tests++; if (err_cnt !== 2'd0) begin fails++; $display("FAIL fl_err_cnt got %0d exp 0", err_cnt); end
    out_ready = 1'b1;
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fl_no_ghost got %0b exp 0", out_valid); end
    in_valid = 1'b1;
    in_inst  = 32'h00600093;
    step();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || out_imm !== 32'd6) begin fails++; $display("FAIL fl_resume got v%0b %h exp v1 00000006", out_valid, out_imm); end
    step();
  endtask

  task automatic test_illegal();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_inst  = 32'hFFFFFF80 ^ (32'(i) << 12);
      step();
      tests++; if (out_fmt !== 3'd7) begin fails++; $display("FAIL ill_fmt[%0d] got %0d exp 7", i, out_fmt); end
      tests++; if (out_illegal !== 1'b1) begin fails++; $display("FAIL ill_flag[%0d] got %0b exp 1", i, out_illegal); end
      tests++; if (out_imm !== 32'h0) begin fails++; $display("FAIL ill_imm[%0d] got %h exp 0", i, out_imm); end
      tests++; if (err_cnt !== exp_cnt[i]) begin fails++; $display("FAIL ill_cnt[%0d] got %0d exp %0d", i, err_cnt, exp_cnt[i]); end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'hFFF00093;
    step();
    in_inst = 32'h00200093;
    step();
    in_valid = 1'b0;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rm_full_ready got %0b exp 0", in_ready); end
    #3;
    rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || out_imm !== 32'h0 || out_fmt !== 3'd0 || out_illegal !== 1'b0) begin
      fails++; $display("FAIL rm_outputs got v%0b %h f%0d i%0b exp all 0", out_valid, out_imm, out_fmt, out_illegal);
    end
    tests++; if (err_cnt !== 2'd0) begin fails++; $display("FAIL rm_err_cnt got %0d exp 0", err_cnt); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rm_ready got %0b exp 1", in_ready); end
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_inst   = 32'h00700093;
    step();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || out_imm !== 32'd7 || out_fmt !== 3'd1) begin
      fails++; $display("FAIL rm_resume got v%0b %h f%0d exp v1 00000007 f1", out_valid, out_imm, out_fmt);
    end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rm_drain got %0b exp 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_xlen64();
    test_backpressure();
    test_flush();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
